// File: rtl/rca32_adder_if.sv
// Operand/result bundle for the ripple-carry adder.
// The requester drives a, b and c0, and the adder returns the registered s and c.
interface rca32_adder_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c0;
   logic [WIDTH-1:0] s;
   logic             c;

   modport master (
      output a,
      output b,
      output c0,
      input  s,
      input  c
   );

   modport slave (
      input  a,
      input  b,
      input  c0,
      output s,
      output c
   );
endinterface

// File: rtl/rca32_adder.sv
// Ripple-carry adder built from a chain of one-bit full adders.
// The sum and carry-out are registered once to isolate timing from downstream logic.
module rca32_full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   logic half_sum;

   assign half_sum = a ^ b;
   assign sum      = half_sum ^ cin;
   assign cout     = (a & b) | (cin & half_sum);
endmodule

module rca32_adder #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   rca32_adder_if.slave       bus
);
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_comb;

   assign carry[0] = bus.c0;

   // Each stage takes its carry from the stage below, so the worst-case path is a full ripple.
   for (genvar i = 0; i < WIDTH; i++) begin : g_chain
      rca32_full_adder u_fa (
         .a    (bus.a[i]),
         .b    (bus.b[i]),
         .cin  (carry[i]),
         .sum  (sum_comb[i]),
         .cout (carry[i+1])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.s <= '0;
         bus.c <= 1'b0;
      end else begin
         bus.s <= sum_comb;
         bus.c <= carry[WIDTH];
      end
   end
endmodule

// File: tb/tb_rca32_adder.sv
// Self-checking bench for rca32_adder.
// It applies directed vectors, reset sequences and random operands, and compares the results against plain 33-bit arithmetic.
module tb_rca32_adder;
   localparam int WIDTH = 32;

   typedef struct {
      string            name;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             c0;
      logic [WIDTH-1:0] exp_s;
      logic             exp_c;
   } vec_t;

   logic clk;
   logic rst_n;
   int   check_count;
   int   pass_count;

   rca32_adder_if #(.WIDTH(WIDTH)) bus ();

   rca32_adder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic c0);
      bus.a  = a;
      bus.b  = b;
      bus.c0 = c0;
   endtask

   task automatic checkOutput(input string name, input logic [WIDTH-1:0] exp_s,
                              input logic exp_c);
      check_count++;
      if (bus.s === exp_s && bus.c === exp_c) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got s=%h c=%b, expected s=%h c=%b",
                  name, bus.s, bus.c, exp_s, exp_c);
      end
   endtask

   // Outputs are sampled 1 time unit after the rising edge, well clear of the capture edge.
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WIDTH:0] refSum(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b, input logic c0);
      return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c0};
   endfunction

   initial begin
      vec_t            vecs[$];
      logic [WIDTH:0]  ref_val;
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rc;

      check_count = 0;
      pass_count  = 0;
      rst_n       = 1'b1;
      applyStimulus('0, '0, 1'b0);

      vecs.push_back('{"dir0",      32'd1000,     32'd10000,    1'b1, 32'd11001,    1'b0});
      vecs.push_back('{"dir1",      32'd1043500,  32'd10546000, 1'b0, 32'd11589500, 1'b0});
      vecs.push_back('{"dir2",      32'd1005670,  32'd1087000,  1'b0, 32'd2092670,  1'b0});
      vecs.push_back('{"dir3",      32'd1323000,  32'd13320000, 1'b0, 32'd14643000, 1'b0});
      vecs.push_back('{"dir4",      32'd14000,    32'd102000,   1'b1, 32'd116001,   1'b0});
      vecs.push_back('{"ripple",    32'hFFFF_FFFF, 32'h0,       1'b1, 32'h0,        1'b1});
      vecs.push_back('{"msb_carry", 32'h7FFF_FFFF, 32'h1,       1'b0, 32'h8000_0000, 1'b0});
      vecs.push_back('{"max",       32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1});
      vecs.push_back('{"zero",      32'h0,        32'h0,        1'b0, 32'h0,        1'b0});

      #2 rst_n = 1'b0;
      #1 checkOutput("reset_init", '0, 1'b0);
      stepCycle();
      rst_n = 1'b1;

      // Load non-zero outputs, then reset between edges to prove the clear is asynchronous.
      applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      stepCycle();
      checkOutput("stale_load", 32'hFFFF_FFFF, 1'b1);
      rst_n = 1'b0;
      #1 checkOutput("reset_async", '0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(32'd5, 32'd7, 1'b1);
      stepCycle();
      checkOutput("reset_release", 32'd13, 1'b0);

      // The directed table runs back-to-back, with one new operand set per cycle.
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c0);
         stepCycle();
         checkOutput(vecs[i].name, vecs[i].exp_s, vecs[i].exp_c);
      end

      // Check that the result lags by exactly one cycle: the new operands must not show before the edge.
      applyStimulus(32'd100, 32'd200, 1'b0);
      stepCycle();
      applyStimulus(32'd1, 32'd2, 1'b0);
      #1 checkOutput("lag_hold", 32'd300, 1'b0);
      stepCycle();
      checkOutput("lag_update", 32'd3, 1'b0);

      // Assert reset mid-stream, hold it across an edge, then resume.
      applyStimulus(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
      rst_n = 1'b0;
      #1 checkOutput("midreset_async", '0, 1'b0);
      stepCycle();
      checkOutput("midreset_hold", '0, 1'b0);
      rst_n = 1'b1;
      stepCycle();
      ref_val = refSum(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
      checkOutput("midreset_resume", ref_val[WIDTH-1:0], ref_val[WIDTH]);

      for (int i = 0; i < 10000; i++) begin
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         rc = 1'($urandom_range(0, 1));
         if (i % 16 == 0) ra = ~rb;
         applyStimulus(ra, rb, rc);
         stepCycle();
         ref_val = refSum(ra, rb, rc);
         checkOutput("random", ref_val[WIDTH-1:0], ref_val[WIDTH]);
      end

      $display("[TB] %0d/%0d checks passed", pass_count, check_count);
      $finish;
   end
endmodule
